pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall/flush generation, control registers, exception/interrupt/EXRT/WRCR handling.
// Stall, flush and new_pc are zero-latency combinational; register effects land on the next clk edge.
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_busy,
  input  logic        mem_busy,
  input  logic        ld_hazard,
  input  logic        mem_en,
  input  logic [29:0] mem_pc,
  input  logic [1:0]  mem_ctrl_op,
  input  logic [2:0]  mem_exp_code,
  input  logic [4:0]  mem_dst_addr,
  input  logic [31:0] mem_out,
  input  logic [7:0]  irq,
  input  logic [4:0]  creg_rd_addr,
  output logic [31:0] creg_rd_data,
  output logic        exe_mode,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        mem_stall,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        mem_flush,
  output logic [29:0] new_pc,
  output logic        int_detect
);

  localparam logic [1:0] OP_WRCR     = 2'd1;
  localparam logic [1:0] OP_EXRT     = 2'd2;
  localparam logic [2:0] EXP_NONE    = 3'd0;
  localparam logic [2:0] EXP_EXT_INT = 3'd1;

  localparam logic [4:0] CREG_STATUS     = 5'd0;
  localparam logic [4:0] CREG_PRE_STATUS = 5'd1;
  localparam logic [4:0] CREG_EPC        = 5'd2;
  localparam logic [4:0] CREG_EXP_VECTOR = 5'd3;
  localparam logic [4:0] CREG_CAUSE      = 5'd4;
  localparam logic [4:0] CREG_INT_MASK   = 5'd5;
  localparam logic [4:0] CREG_IRQ        = 5'd6;

  typedef struct packed {
    logic int_en;
    logic exe_mode;
  } status_t;

  typedef enum logic [2:0] {
    EVT_NONE = 3'd0,
    EVT_EXP  = 3'd1,
    EVT_INT  = 3'd2,
    EVT_EXRT = 3'd3,
    EVT_WRCR = 3'd4
  } evt_e;

  status_t     r_status;
  status_t     r_pre_status;
  logic [29:0] r_epc;
  logic [29:0] r_exp_vector;
  logic [2:0]  r_cause;
  logic [7:0]  r_int_mask;

  logic        w_stall;
  logic        w_evt_ok;
  evt_e        w_evt;
  logic        w_unused;

  // No control register is wider than 30 bits.
  assign w_unused = ^mem_out[31:30];

  assign w_stall    = if_busy | mem_busy;
  assign w_evt_ok   = mem_en & ~w_stall;
  assign if_stall   = w_stall | ld_hazard;
  assign id_stall   = w_stall;
  assign ex_stall   = w_stall;
  assign mem_stall  = w_stall;
  assign exe_mode   = r_status.exe_mode;
  assign int_detect = r_status.int_en & (|(irq & ~r_int_mask));

  always_comb begin
    creg_rd_data = '0;
    case (creg_rd_addr)
      CREG_STATUS:     creg_rd_data = {30'd0, r_status};
      CREG_PRE_STATUS: creg_rd_data = {30'd0, r_pre_status};
      CREG_EPC:        creg_rd_data = {2'd0, r_epc};
      CREG_EXP_VECTOR: creg_rd_data = {2'd0, r_exp_vector};
      CREG_CAUSE:      creg_rd_data = {29'd0, r_cause};
      CREG_INT_MASK:   creg_rd_data = {24'd0, r_int_mask};
      CREG_IRQ:        creg_rd_data = {24'd0, irq};
      default:         creg_rd_data = '0;
    endcase
  end

  // A single MEM slot carries at most one event; exceptions outrank interrupts.
  always_comb begin
    w_evt = EVT_NONE;
    if (w_evt_ok) begin
      if (mem_exp_code != EXP_NONE)  w_evt = EVT_EXP;
      else if (int_detect)           w_evt = EVT_INT;
      else if (mem_ctrl_op == OP_EXRT) w_evt = EVT_EXRT;
      else if (mem_ctrl_op == OP_WRCR) w_evt = EVT_WRCR;
    end
  end

  always_comb begin
    {if_flush, id_flush, ex_flush, mem_flush} = 4'b0000;
    new_pc = '0;
    case (w_evt)
      EVT_EXP, EVT_INT: begin
        {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
        new_pc = r_exp_vector;
      end
      EVT_EXRT: begin
        {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
        new_pc = r_epc;
      end
      EVT_WRCR: begin
        {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
        new_pc = mem_pc + 30'd1;
      end
      default: begin
        // Load-use: hold IF/ID and push a bubble into EX.
        if (!w_stall && ld_hazard) id_flush = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_status     <= '0;
      r_pre_status <= '0;
      r_epc        <= '0;
      r_exp_vector <= '0;
      r_cause      <= '0;
      r_int_mask   <= 8'hFF;
    end else begin
      case (w_evt)
        EVT_EXP, EVT_INT: begin
          r_pre_status <= r_status;
          r_status     <= '0;
          r_epc        <= mem_pc;
          r_cause      <= (w_evt == EVT_EXP) ? mem_exp_code : EXP_EXT_INT;
        end
        EVT_EXRT: r_status <= r_pre_status;
        EVT_WRCR: begin
          case (mem_dst_addr)
            CREG_STATUS:     r_status     <= status_t'(mem_out[1:0]);
            CREG_PRE_STATUS: r_pre_status <= status_t'(mem_out[1:0]);
            CREG_EPC:        r_epc        <= mem_out[29:0];
            CREG_EXP_VECTOR: r_exp_vector <= mem_out[29:0];
            CREG_CAUSE:      r_cause      <= mem_out[2:0];
            CREG_INT_MASK:   r_int_mask   <= mem_out[7:0];
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic against a register-array reference model.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_busy, mem_busy, ld_hazard, mem_en;
  logic [29:0] mem_pc;
  logic [1:0]  mem_ctrl_op;
  logic [2:0]  mem_exp_code;
  logic [4:0]  mem_dst_addr;
  logic [31:0] mem_out;
  logic [7:0]  irq;
  logic [4:0]  creg_rd_addr;
  logic [31:0] creg_rd_data;
  logic        exe_mode;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush;
  logic [29:0] new_pc;
  logic        int_detect;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: control registers 0..5 held as plain words.
  logic [31:0] m_creg [0:5];

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .if_busy(if_busy), .mem_busy(mem_busy),
    .ld_hazard(ld_hazard), .mem_en(mem_en), .mem_pc(mem_pc),
    .mem_ctrl_op(mem_ctrl_op), .mem_exp_code(mem_exp_code),
    .mem_dst_addr(mem_dst_addr), .mem_out(mem_out), .irq(irq),
    .creg_rd_addr(creg_rd_addr), .creg_rd_data(creg_rd_data),
    .exe_mode(exe_mode), .if_stall(if_stall), .id_stall(id_stall),
    .ex_stall(ex_stall), .mem_stall(mem_stall), .if_flush(if_flush),
    .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .new_pc(new_pc), .int_detect(int_detect)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] wmask(input int a);
    case (a)
      0, 1:    return 32'h0000_0003;
      2, 3:    return 32'h3FFF_FFFF;
      4:       return 32'h0000_0007;
      5:       return 32'h0000_00FF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit model_int();
    return m_creg[0][1] && ((irq & ~m_creg[5][7:0]) != 8'd0);
  endfunction

  // 0 none, 1 exception, 2 interrupt, 3 EXRT, 4 WRCR
  function automatic int model_evt();
    if (!mem_en || if_busy || mem_busy) return 0;
    if (mem_exp_code != 3'd0) return 1;
    if (model_int()) return 2;
    if (mem_ctrl_op == 2'd2) return 3;
    if (mem_ctrl_op == 2'd1) return 4;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_creg[i] = 32'd0;
    m_creg[5] = 32'h0000_00FF;
  endtask

  task automatic check_now();
    int          evt;
    bit          st;
    logic [3:0]  e_stall, e_flush;
    logic [29:0] e_pc;
    logic [31:0] e_rd;
    logic [63:0] nxt;
    #2;
    st  = if_busy || mem_busy;
    evt = model_evt();
    e_stall = {st || ld_hazard, st, st, st};
    if (evt != 0) e_flush = 4'hF;
    else if (!st && ld_hazard) e_flush = 4'b0100;
    else e_flush = 4'b0000;
    nxt = ({34'd0, mem_pc} + 64'd1) % 64'h4000_0000;
    case (evt)
      1, 2:    e_pc = m_creg[3][29:0];
      3:       e_pc = m_creg[2][29:0];
      4:       e_pc = nxt[29:0];
      default: e_pc = 30'd0;
    endcase
    if (creg_rd_addr < 5'd6) e_rd = m_creg[int'(creg_rd_addr)];
    else if (creg_rd_addr == 5'd6) e_rd = {24'd0, irq};
    else e_rd = 32'd0;
    chk("stalls", 32'({if_stall, id_stall, ex_stall, mem_stall}), 32'(e_stall));
    chk("flushes", 32'({if_flush, id_flush, ex_flush, mem_flush}), 32'(e_flush));
    chk("new_pc", 32'(new_pc), 32'(e_pc));
    chk("int_detect", 32'(int_detect), 32'(model_int()));
    chk("exe_mode", 32'(exe_mode), 32'(m_creg[0][0]));
    chk("creg_rd_data", creg_rd_data, e_rd);
  endtask

  task automatic tick();
    int evt;
    @(posedge clk);
    evt = model_evt();
    if (reset) model_reset();
    else begin
      case (evt)
        1, 2: begin
          m_creg[1] = m_creg[0];
          m_creg[0] = 32'd0;
          m_creg[2] = {2'd0, mem_pc};
          m_creg[4] = (evt == 1) ? {29'd0, mem_exp_code} : 32'd1;
        end
        3: m_creg[0] = m_creg[1];
        4: if (mem_dst_addr < 5'd6)
             m_creg[int'(mem_dst_addr)] = mem_out & wmask(int'(mem_dst_addr));
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic set_idle();
    reset = 0; if_busy = 0; mem_busy = 0; ld_hazard = 0; mem_en = 0;
    mem_pc = '0; mem_ctrl_op = '0; mem_exp_code = '0; mem_dst_addr = '0;
    mem_out = '0; irq = '0; creg_rd_addr = '0;
  endtask

  task automatic wrcr(input logic [4:0] a, input logic [31:0] d);
    set_idle(); mem_en = 1; mem_ctrl_op = 2'd1; mem_dst_addr = a; mem_out = d;
    check_now(); tick();
  endtask

  task automatic read_chk(input string tag, input logic [4:0] a, input logic [31:0] expv);
    set_idle(); creg_rd_addr = a;
    check_now(); chk(tag, creg_rd_data, expv); tick();
  endtask

  initial begin
    for (int i = 0; i < 6; i++) m_creg[i] = 32'd0;
    set_idle(); reset = 1; mem_en = 1; mem_exp_code = 3'd3;
    tick();
    // Reset wins over a concurrent WRCR.
    set_idle(); reset = 1; mem_en = 1; mem_ctrl_op = 2'd1; mem_dst_addr = 5'd5; mem_out = 32'd0;
    check_now(); tick();

    set_idle(); irq = 8'hFF;
    check_now();
    chk("rst_status", creg_rd_data, 32'd0);
    chk("rst_exe_mode", 32'(exe_mode), 32'd0);
    chk("rst_int_detect", 32'(int_detect), 32'd0);
    tick();
    read_chk("rst_exp_vector", 5'd3, 32'd0);
    read_chk("rst_int_mask", 5'd5, 32'h0000_00FF);

    set_idle(); mem_en = 1; mem_ctrl_op = 2'd1; mem_dst_addr = 5'd3; mem_out = 32'h100; mem_pc = 30'h10;
    check_now();
    chk("wrcr_flush", 32'({if_flush, id_flush, ex_flush, mem_flush}), 32'hF);
    chk("wrcr_new_pc", 32'(new_pc), 32'h11);
    tick();
    read_chk("wrcr_readback", 5'd3, 32'h100);

    wrcr(5'd3, 32'h40);
    wrcr(5'd0, 32'h3);
    set_idle(); mem_en = 1; mem_exp_code = 3'd6; mem_pc = 30'h25;
    check_now();
    chk("exc_flush", 32'({if_flush, id_flush, ex_flush, mem_flush}), 32'hF);
    chk("exc_new_pc", 32'(new_pc), 32'h40);
    tick();
    read_chk("exc_status", 5'd0, 32'h0);
    read_chk("exc_pre_status", 5'd1, 32'h3);
    read_chk("exc_epc", 5'd2, 32'h25);
    read_chk("exc_cause", 5'd4, 32'h6);
    set_idle(); mem_en = 1; mem_ctrl_op = 2'd2;
    check_now();
    chk("exrt_new_pc", 32'(new_pc), 32'h25);
    tick();
    read_chk("exrt_status", 5'd0, 32'h3);

    wrcr(5'd5, 32'hFE);
    set_idle(); irq = 8'h02;
    check_now(); chk("irq_masked", 32'(int_detect), 32'd0); tick();
    set_idle(); irq = 8'h01;
    check_now(); chk("irq_detect", 32'(int_detect), 32'd1); tick();
    set_idle(); irq = 8'h01; mem_en = 1; mem_pc = 30'h33;
    check_now(); chk("irq_new_pc", 32'(new_pc), 32'h40); tick();
    read_chk("irq_cause", 5'd4, 32'h1);
    read_chk("irq_status", 5'd0, 32'h0);

    set_idle(); mem_busy = 1; mem_en = 1; mem_exp_code = 3'd5; creg_rd_addr = 5'd4;
    check_now();
    chk("busy_stalls", 32'({if_stall, id_stall, ex_stall, mem_stall}), 32'hF);
    chk("busy_flush", 32'({if_flush, id_flush, ex_flush, mem_flush}), 32'h0);
    tick();
    check_now(); chk("busy_cause", creg_rd_data, 32'h1);
    tick();
    mem_busy = 0;
    check_now(); chk("unbusy_flush", 32'({if_flush, id_flush, ex_flush, mem_flush}), 32'hF);
    tick();
    read_chk("unbusy_cause", 5'd4, 32'h5);

    set_idle(); ld_hazard = 1; mem_en = 1;
    check_now();
    chk("ldh_stalls", 32'({if_stall, id_stall, ex_stall, mem_stall}), 32'h8);
    chk("ldh_flush", 32'({if_flush, id_flush, ex_flush, mem_flush}), 32'h4);
    tick();

    set_idle(); mem_en = 1; mem_ctrl_op = 2'd1; mem_dst_addr = 5'd7; mem_pc = 30'h3FFF_FFFF;
    check_now(); chk("wrap_new_pc", 32'(new_pc), 32'h0); tick();

    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(0, 99) == 0);
      if_busy      = ($urandom_range(0, 5) == 0);
      mem_busy     = ($urandom_range(0, 5) == 0);
      mem_en       = ($urandom_range(0, 3) != 0);
      ld_hazard    = mem_en && ($urandom_range(0, 3) == 0);
      mem_pc       = ($urandom_range(0, 15) == 0) ? 30'h3FFF_FFFF : 30'($urandom);
      mem_ctrl_op  = 2'($urandom);
      mem_exp_code = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      mem_dst_addr = 5'($urandom_range(0, 7));
      mem_out      = $urandom;
      irq          = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'd0;
      creg_rd_addr = 5'($urandom_range(0, 8));
      check_now();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
